// File: rtl/bram_fifo_ctrl_if.sv
// Valid/ready word stream used on both sides of the BRAM FIFO controller.
interface bram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/bram_fifo_ctrl.sv
// FIFO controller around a simple-dual-port BRAM with 2-cycle read latency;
// reads are prefetched through the BRAM pipeline into a 3-entry skid buffer.
module bram_fifo_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clka,
  input  logic                  rsta,
  bram_fifo_ctrl_if.slave       s,
  bram_fifo_ctrl_if.master      m,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic                  ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  output logic                  ram_enb,
  output logic                  ram_regceb,
  output logic                  ram_rstb,
  input  logic [DATA_WIDTH-1:0] ram_doutb
);

  localparam int OCC_W = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   ram_occ;
  logic                  vld_p1;
  logic                  vld_p2;
  logic [2:0]            skid_cnt;
  logic [1:0]            skid_head;
  logic [1:0]            skid_tail;
  logic [DATA_WIDTH-1:0] skid_mem [3];

  logic                  push;
  logic                  pop;
  logic                  issue;
  logic [2:0]            inflight;

  function automatic logic [1:0] skid_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // ram_occ never exceeds DEPTH (a power of 2), so its MSB alone means full.
  assign s.ready  = ~ram_occ[ADDR_WIDTH];
  assign push     = s.valid & s.ready & ~rsta;

  assign m.valid  = (skid_cnt != 3'd0);
  assign m.data   = skid_mem[skid_head];
  assign pop      = m.valid & m.ready;

  // Credit: every word in the read pipeline already owns a skid slot.
  assign inflight = skid_cnt + {2'b00, vld_p1} + {2'b00, vld_p2};
  assign issue    = ~rsta & (ram_occ != '0) & (inflight < (3'd3 + {2'b00, pop}));

  assign ram_wea    = push;
  assign ram_addra  = wptr;
  assign ram_dina   = s.data;
  assign ram_enb    = issue;
  assign ram_addrb  = rptr;
  assign ram_regceb = vld_p1;
  assign ram_rstb   = rsta;

  assign count = ram_occ + OCC_W'(vld_p1) + OCC_W'(vld_p2) + OCC_W'(skid_cnt);

  always_ff @(posedge clka) begin
    if (rsta) begin
      wptr      <= '0;
      rptr      <= '0;
      ram_occ   <= '0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      skid_cnt  <= '0;
      skid_head <= '0;
      skid_tail <= '0;
    end else begin
      if (push)  wptr <= wptr + ADDR_WIDTH'(1);
      if (issue) rptr <= rptr + ADDR_WIDTH'(1);

      unique case ({push, issue})
        2'b10:   ram_occ <= ram_occ + OCC_W'(1);
        2'b01:   ram_occ <= ram_occ - OCC_W'(1);
        default: ram_occ <= ram_occ;
      endcase

      // Read pipeline: p1 = BRAM array read, p2 = BRAM output register.
      vld_p1 <= issue;
      vld_p2 <= vld_p1;

      if (vld_p2) skid_tail <= skid_inc(skid_tail);
      if (pop)    skid_head <= skid_inc(skid_head);

      unique case ({vld_p2, pop})
        2'b10:   skid_cnt <= skid_cnt + 3'd1;
        2'b01:   skid_cnt <= skid_cnt - 3'd1;
        default: skid_cnt <= skid_cnt;
      endcase
    end
  end

  always_ff @(posedge clka) begin
    if (vld_p2) skid_mem[skid_tail] <= ram_doutb;
  end

  a_skid_bound: assert property (@(posedge clka) disable iff (rsta)
    skid_cnt <= 3'd3);

  a_skid_no_overflow: assert property (@(posedge clka) disable iff (rsta)
    !(vld_p2 && (skid_cnt == 3'd3) && !pop));

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Bench for bram_fifo_ctrl: BRAM behavioural model, per-cycle vector table
// and directed fill/drain/stream/reset sequences.
module tb_bram_fifo_ctrl;
  localparam int DW    = 64;
  localparam int DEPTH = 512;
  localparam int AW    = $clog2(DEPTH);

  logic          clka = 1'b0;
  logic          rsta;
  logic [AW:0]   count;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dina, ram_doutb;
  logic          ram_wea, ram_enb, ram_regceb, ram_rstb;

  bram_fifo_ctrl_if #(.DATA_WIDTH(DW)) s_if ();
  bram_fifo_ctrl_if #(.DATA_WIDTH(DW)) m_if ();

  bram_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clka(clka), .rsta(rsta), .s(s_if), .m(m_if), .count(count),
    .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_wea(ram_wea),
    .ram_addrb(ram_addrb), .ram_enb(ram_enb), .ram_regceb(ram_regceb),
    .ram_rstb(ram_rstb), .ram_doutb(ram_doutb)
  );

  always #5 clka = ~clka;

  // BRAM model: array read on enb, output register on regceb, reset by rstb.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_p1;
  always @(posedge clka) begin
    if (ram_wea) mem[ram_addra] <= ram_dina;
    if (ram_enb) rd_p1 <= mem[ram_addrb];
    if (ram_rstb)        ram_doutb <= '0;
    else if (ram_regceb) ram_doutb <= rd_p1;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        sv;
    logic [63:0] sd;
    logic        mr;
    logic        e_sready;
    logic        e_mvalid;
    logic [63:0] e_mdata;
    int          e_count;
    logic        e_wea;
    int          e_addra;
    logic        e_enb;
    int          e_addrb;
    logic        e_regceb;
  } vec_t;

  vec_t vecs [14];
  logic [63:0] q [$];

  initial begin
    // sv sd mr | s_ready m_valid m_data count wea addra enb addrb regceb
    vecs[0]  = '{1'b1, 64'hA5, 1'b1, 1'b1, 1'b0, 64'h0,  0, 1'b1, 0, 1'b0, 0, 1'b0};
    vecs[1]  = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 64'h0,  1, 1'b0, 0, 1'b1, 0, 1'b0};
    vecs[2]  = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 64'h0,  1, 1'b0, 0, 1'b0, 0, 1'b1};
    vecs[3]  = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 64'h0,  1, 1'b0, 0, 1'b0, 0, 1'b0};
    vecs[4]  = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'hA5, 1, 1'b0, 0, 1'b0, 0, 1'b0};
    vecs[5]  = '{1'b0, 64'h0,  1'b0, 1'b1, 1'b0, 64'h0,  0, 1'b0, 0, 1'b0, 0, 1'b0};
    vecs[6]  = '{1'b1, 64'h11, 1'b0, 1'b1, 1'b0, 64'h0,  0, 1'b1, 1, 1'b0, 0, 1'b0};
    vecs[7]  = '{1'b1, 64'h22, 1'b0, 1'b1, 1'b0, 64'h0,  1, 1'b1, 2, 1'b1, 1, 1'b0};
    vecs[8]  = '{1'b0, 64'h0,  1'b0, 1'b1, 1'b0, 64'h0,  2, 1'b0, 0, 1'b1, 2, 1'b1};
    vecs[9]  = '{1'b0, 64'h0,  1'b0, 1'b1, 1'b0, 64'h0,  2, 1'b0, 0, 1'b0, 0, 1'b1};
    vecs[10] = '{1'b0, 64'h0,  1'b0, 1'b1, 1'b1, 64'h11, 2, 1'b0, 0, 1'b0, 0, 1'b0};
    vecs[11] = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'h11, 2, 1'b0, 0, 1'b0, 0, 1'b0};
    vecs[12] = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'h22, 1, 1'b0, 0, 1'b0, 0, 1'b0};
    vecs[13] = '{1'b0, 64'h0,  1'b0, 1'b1, 1'b0, 64'h0,  0, 1'b0, 0, 1'b0, 0, 1'b0};

    rsta = 1'b1;
    s_if.valid = 1'b0;
    s_if.data  = '0;
    m_if.ready = 1'b0;

    // Reset held for two edges
    @(negedge clka);
    @(negedge clka);
    #1;
    chk("rst ram_rstb", 64'(ram_rstb), 64'd1);
    chk("rst ram_wea",  64'(ram_wea),  64'd0);
    chk("rst ram_enb",  64'(ram_enb),  64'd0);
    @(negedge clka);
    rsta = 1'b0;
    #1;
    chk("rst s_ready",  64'(s_if.ready),  64'd1);
    chk("rst m_valid",  64'(m_if.valid),  64'd0);
    chk("rst count",    64'(count),       64'd0);
    chk("rel ram_rstb", 64'(ram_rstb),    64'd0);
    chk("rel ram_wea",  64'(ram_wea),     64'd0);
    chk("rel ram_enb",  64'(ram_enb),     64'd0);

    // Cycle-exact vector table
    for (int i = 0; i < 14; i++) begin
      @(negedge clka);
      s_if.valid = vecs[i].sv;
      s_if.data  = vecs[i].sd;
      m_if.ready = vecs[i].mr;
      #1;
      chk($sformatf("vec%0d s_ready", i), 64'(s_if.ready), 64'(vecs[i].e_sready));
      chk($sformatf("vec%0d m_valid", i), 64'(m_if.valid), 64'(vecs[i].e_mvalid));
      chk($sformatf("vec%0d count", i),   64'(count),      64'(vecs[i].e_count));
      chk($sformatf("vec%0d wea", i),     64'(ram_wea),    64'(vecs[i].e_wea));
      chk($sformatf("vec%0d enb", i),     64'(ram_enb),    64'(vecs[i].e_enb));
      chk($sformatf("vec%0d regceb", i),  64'(ram_regceb), 64'(vecs[i].e_regceb));
      if (vecs[i].e_mvalid) chk($sformatf("vec%0d m_data", i), m_if.data, vecs[i].e_mdata);
      if (vecs[i].e_wea) begin
        chk($sformatf("vec%0d addra", i), 64'(ram_addra), 64'(vecs[i].e_addra));
        chk($sformatf("vec%0d dina", i),  ram_dina,       vecs[i].sd);
      end
      if (vecs[i].e_enb) chk($sformatf("vec%0d addrb", i), 64'(ram_addrb), 64'(vecs[i].e_addrb));
    end

    // Fill with the sink stalled: RAM plus three skid entries
    begin
      int acc = 0;
      m_if.ready = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        @(negedge clka);
        s_if.valid = 1'b1;
        s_if.data  = 64'(acc);
        #1;
        chk("fill count", 64'(count), 64'(acc));
        if (s_if.ready) acc++;
      end
      chk("fill accepted", 64'(acc), 64'd515);
      @(negedge clka);
      #1;
      chk("full s_ready", 64'(s_if.ready), 64'd0);
      chk("full wea",     64'(ram_wea),    64'd0);
      chk("full count",   64'(count),      64'd515);
      chk("full m_valid", 64'(m_if.valid), 64'd1);
      chk("full m_data",  m_if.data,       64'd0);
    end

    // Drain: one word per cycle, no bubbles, in order
    for (int i = 0; i < 515; i++) begin
      @(negedge clka);
      s_if.valid = 1'b0;
      m_if.ready = 1'b1;
      #1;
      chk($sformatf("drain%0d m_valid", i), 64'(m_if.valid), 64'd1);
      chk($sformatf("drain%0d m_data", i),  m_if.data,       64'(i));
    end
    @(negedge clka);
    #1;
    chk("drained m_valid", 64'(m_if.valid), 64'd0);
    chk("drained count",   64'(count),      64'd0);

    // Streaming with random back-pressure across several pointer wraps
    begin
      int sent = 0;
      int rcvd = 0;
      for (int cyc = 0; cyc < 12000 && rcvd < 2000; cyc++) begin
        @(negedge clka);
        s_if.valid = (sent < 2000);
        s_if.data  = {32'h5A5A0000, 32'(sent)};
        m_if.ready = 1'($urandom_range(0, 1));
        #1;
        chk("stream count", 64'(count), 64'(q.size()));
        if (m_if.valid && m_if.ready) begin
          if (q.size() == 0) chk("stream unexpected word", m_if.data, 64'hDEAD);
          else chk($sformatf("stream word%0d", rcvd), m_if.data, q.pop_front());
          rcvd++;
        end
        if (s_if.valid && s_if.ready) begin
          q.push_back(s_if.data);
          sent++;
        end
      end
      chk("stream received", 64'(rcvd), 64'd2000);
      @(negedge clka);
      s_if.valid = 1'b0;
      m_if.ready = 1'b0;
      #1;
      chk("stream end count", 64'(count), 64'd0);
    end

    // Reset with two reads in flight
    for (int i = 0; i < 10; i++) begin
      @(negedge clka);
      s_if.valid = 1'b1;
      s_if.data  = 64'(100 + i);
      m_if.ready = 1'b0;
    end
    @(negedge clka);
    s_if.valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clka);
      m_if.ready = 1'b1;
      #1;
      chk($sformatf("pre-rst m_data%0d", i), m_if.data, 64'(100 + i));
      chk($sformatf("pre-rst enb%0d", i),    64'(ram_enb), 64'd1);
    end
    @(negedge clka);
    m_if.ready = 1'b0;
    rsta = 1'b1;
    #1;
    chk("mid rst ram_rstb", 64'(ram_rstb), 64'd1);
    @(negedge clka);
    rsta = 1'b0;
    s_if.valid = 1'b1;
    s_if.data  = 64'h77;
    #1;
    chk("post rst m_valid", 64'(m_if.valid), 64'd0);
    chk("post rst count",   64'(count),      64'd0);
    chk("post rst s_ready", 64'(s_if.ready), 64'd1);
    chk("post rst wea",     64'(ram_wea),    64'd1);
    chk("post rst addra",   64'(ram_addra),  64'd0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clka);
      s_if.valid = 1'b0;
      m_if.ready = 1'b1;
      #1;
      chk($sformatf("post rst c%0d m_valid", k), 64'(m_if.valid), 64'd0);
    end
    @(negedge clka);
    #1;
    chk("post rst c4 m_valid", 64'(m_if.valid), 64'd1);
    chk("post rst c4 m_data",  m_if.data,       64'h77);
    @(negedge clka);
    #1;
    chk("post rst c5 count",   64'(count),      64'd0);
    chk("post rst c5 m_valid", 64'(m_if.valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bram_fifo_ctrl.md
Name: bram_fifo_ctrl

Overview:
- Synchronous FIFO controller that drives one simple-dual-port single-clock BRAM configured for 2-cycle read latency (output register enabled).
- Owns the write side: write pointer, `wea`, `dina`.
- Owns the read side: read pointer, `enb`, `regceb`, `rstb`.
- Tracks the 2-cycle read pipeline and prefetches into a 3-entry output skid buffer, presenting a standard valid/ready stream downstream.

Parameters:
- DATA_WIDTH, 64, word width; equals the BRAM RAM_WIDTH.
- DEPTH, 512, BRAM entries; must be a power of 2, ≥4.
- ADDR_WIDTH, log2(DEPTH), BRAM address width.

Ports:
- clka  in  1  clock; all logic on its rising edge.
- rsta  in  1  reset, synchronous, active-high.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  controller accepts a word this cycle.
- s_data  in  DATA_WIDTH  upstream word.
- m_valid  out  1  head of skid buffer valid.
- m_ready  in  1  downstream accepts head.
- m_data  out  DATA_WIDTH  head of skid buffer.
- count  out  ADDR_WIDTH+1  total words held (RAM + in flight + skid).
- ram_addra  out  ADDR_WIDTH  BRAM write address.
- ram_dina  out  DATA_WIDTH  BRAM write data.
- ram_wea  out  1  BRAM write enable.
- ram_addrb  out  ADDR_WIDTH  BRAM read address.
- ram_enb  out  1  BRAM read enable.
- ram_regceb  out  1  BRAM output register enable.
- ram_rstb  out  1  BRAM output register reset.
- ram_doutb  in  DATA_WIDTH  BRAM read data (valid 2 cycles after ram_enb).

Behaviour:

Reset:
- rsta=1 at a clock edge clears wptr, rptr, ram_occ, v1, v2, skid_cnt and skid pointers.
- Next-cycle outputs: s_ready=1, m_valid=0, count=0, ram_wea=0, ram_enb=0.
- ram_rstb = rsta (combinational).
- Reset mid-operation discards all data, including in-flight reads. BRAM contents are not cleared.

Push:
- push = s_valid & s_ready.
- s_ready = (ram_occ < DEPTH); combinational from registers only, never from s_valid.
- ram_wea = push, ram_addra = wptr, ram_dina = s_data.
- wptr increments on push and wraps DEPTH-1 → 0.

Read issue:
- pop = m_valid & m_ready.
- issue = (ram_occ > 0) & (skid_cnt + v1 + v2 − pop < 3).
- ram_enb = issue, ram_addrb = rptr.
- rptr increments on issue and wraps.

Occupancy:
- ram_occ next = ram_occ + push − issue.
- A word written in cycle N is first issuable in cycle N+1. This removes any same-address read/write collision.

Read pipeline:
- v1 <= issue; v2 <= v1.
- ram_regceb = v1.
- When v2=1, ram_doutb is captured into the skid buffer tail at that edge.
- Latency: push accepted in cycle 0 → issue cycle 1 → m_valid=1 in cycle 4, with empty pipeline and skid.

Skid buffer:
- 3-entry circular buffer.
- m_valid = (skid_cnt > 0), m_data = head entry.
- Capture and pop in the same cycle leave skid_cnt unchanged.
- The credit rule guarantees the buffer never overflows. Assert that skid_cnt ≤ 3 and that capture never occurs when skid_cnt = 3 without a pop.

Count and capacity:
- count = ram_occ + v1 + v2 + skid_cnt.
- Maximum count is DEPTH+3: with m_ready held low, 3 words drain to the skid, freeing RAM slots.

Throughput and ordering:
- With s_valid=1 and m_ready=1, sustained 1 word/cycle in and out once the pipeline is primed.
- Strict FIFO order across pointer wrap-around.

Simultaneous events:
- push and issue in the same cycle: both take effect; ram_occ unchanged.
- push while ram_occ=DEPTH: not accepted (s_ready=0).
- issue and pop in the same cycle: handled by the −pop credit term.

Test Plan:
- Reset: assert rsta for 2 cycles, then release → s_ready=1, m_valid=0, count=0, ram_rstb followed rsta; no ram_wea/ram_enb pulses.
- Single word: push 0xA5 at cycle 0, m_ready=1 → ram_wea at cycle 0 addr 0; ram_enb at cycle 1 addr 0; m_valid=1, m_data=0xA5 at cycle 4; count returns to 0 in cycle 5.
- Fill with m_ready=0: push 0..N continuously → exactly 515 words accepted (DEPTH=512); s_ready falls after the 515th; count=515; m_data=0.
- Drain after fill: raise m_ready → 515 words out in order 0..514 at 1/cycle with no bubbles; m_valid falls after the last; count=0.
- Streaming and wrap: 2000 words with s_valid=1 and random m_ready (50%) → output sequence identical to input; pointers wrap ≥3 times; no skid overflow assertion fires.
- Reset mid-operation: 10 words pushed, 2 reads in flight, rsta pulsed → next cycle m_valid=0, count=0; a subsequent push of 0x77 emerges first, 4 cycles later.
